// File: rtl/mem_addr_decoder.sv
// Purpose: recovers 24-bit sample addresses from 26-bit memory-bus addresses, range-checks bits [25:24], counts errors (ADDR_DEC_SEQ_EN adds seq flag).
// Latency: 1 cycle from accept to out_valid when the output register is free or draining.
// Backpressure: 2-entry skid (output + skid register); in_ready is registered and full throughput is kept under stalls.
module mem_addr_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [25:0]      mem_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [23:0]      addr,
    output logic             range_err,
    output logic             seq,
    input  logic             clr_count,
    output logic [CNT_W-1:0] err_count
);

    typedef struct packed {
        logic [23:0] addr;
        logic        range_err;
        logic        seq;
    } ent_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ent_t or_q;
    ent_t sk_q;
    ent_t in_ent;
    logic or_vld;
    logic sk_vld;
    logic in_rdy_q;
    logic accept;
    logic drain;

    assign accept = in_valid & in_rdy_q;
    assign drain  = or_vld & out_ready;

`ifdef ADDR_DEC_SEQ_EN
    logic [23:0] prev_good;
    logic        prev_good_vld;

    // Only in-range entries advance the run; error entries leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_good     <= '0;
            prev_good_vld <= 1'b0;
        end else if (accept && !in_ent.range_err) begin
            prev_good     <= in_ent.addr;
            prev_good_vld <= 1'b1;
        end
    end
`endif

    always_comb begin
        in_ent           = '0;
        in_ent.addr      = mem_addr[23:0];
        in_ent.range_err = |mem_addr[25:24];
`ifdef ADDR_DEC_SEQ_EN
        in_ent.seq       = !in_ent.range_err && prev_good_vld &&
                           (mem_addr[23:0] == prev_good + 24'd1);
`endif
    end

    // in_ready is cleared on entering the skid and restored when it empties,
    // so it never depends combinationally on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_q     <= '0;
            sk_q     <= '0;
            or_vld   <= 1'b0;
            sk_vld   <= 1'b0;
            in_rdy_q <= 1'b1;
        end else if (drain) begin
            if (sk_vld) begin
                or_q     <= sk_q;
                sk_vld   <= 1'b0;
                in_rdy_q <= 1'b1;
            end else if (accept) begin
                or_q <= in_ent;
            end else begin
                or_vld <= 1'b0;
            end
        end else if (accept) begin
            if (!or_vld) begin
                or_q   <= in_ent;
                or_vld <= 1'b1;
            end else begin
                sk_q     <= in_ent;
                sk_vld   <= 1'b1;
                in_rdy_q <= 1'b0;
            end
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (clr_count) begin
            err_count <= '0;
        end else if (accept && in_ent.range_err && (err_count != CNT_MAX)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

    assign in_ready  = in_rdy_q;
    assign out_valid = or_vld;
    assign addr      = or_q.addr;
    assign range_err = or_q.range_err;
    assign seq       = or_q.seq;

endmodule

// File: tb/tb_mem_addr_decoder.sv
// Bench for mem_addr_decoder: directed steps plus random traffic checked against a queue model.
module tb_mem_addr_decoder;
    localparam int CNT_W   = 4;
    localparam int CNT_TOP = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [25:0]      mem_addr = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [23:0]      addr;
    logic             range_err;
    logic             seq;
    logic             clr_count = 1'b0;
    logic [CNT_W-1:0] err_count;

    always #5 clk = ~clk;

    mem_addr_decoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .mem_addr(mem_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .addr(addr), .range_err(range_err), .seq(seq),
        .clr_count(clr_count), .err_count(err_count)
    );

    typedef struct {
        int unsigned a;
        bit          e;
        bit          s;
    } exp_t;

    exp_t        q[$];
    int          cnt_m;
    bit          pg_v;
    int unsigned pg;
    int          n_chk;
    int          n_pass;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_decode(input logic [25:0] m);
        exp_t r;
        r.a = int'(m) % 32'h100_0000;
        r.e = (int'(m) / 32'h100_0000) != 0;
`ifdef ADDR_DEC_SEQ_EN
        r.s = !r.e && pg_v && (r.a == (pg + 1) % 32'h100_0000);
`else
        r.s = 1'b0;
`endif
        return r;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < 2));
        chk({tag, ".err_count"}, 32'(err_count), 32'(cnt_m));
        if (q.size() > 0) begin
            chk({tag, ".addr"}, 32'(addr), q[0].a);
            chk({tag, ".range_err"}, 32'(range_err), 32'(q[0].e));
            chk({tag, ".seq"}, 32'(seq), 32'(q[0].s));
        end
    endtask

    // Model decides the handshake from its own occupancy, then advances one clock.
    task automatic cycle(input string tag);
        bit   acc;
        bit   drn;
        exp_t ne;
        acc = in_valid && (q.size() < 2);
        drn = out_ready && (q.size() > 0);
        ne  = model_decode(mem_addr);
        if (clr_count) cnt_m = 0;
        else if (acc && ne.e && cnt_m < CNT_TOP) cnt_m++;
        if (acc && !ne.e) begin
            pg_v = 1'b1;
            pg   = ne.a;
        end
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(ne);
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        q.delete();
        cnt_m = 0;
        pg_v  = 1'b0;
        pg    = 0;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.addr", 32'(addr), 32'd0);
        chk("rst.range_err", 32'(range_err), 32'd0);
        chk("rst.seq", 32'(seq), 32'd0);
        chk("rst.err_count", 32'(err_count), 32'd0);
    endtask

    initial begin
        logic [25:0] seq_addr [6];
        bit          seq_exp  [6];
        logic [1:0]  hi;
        logic [23:0] lo;

        n_chk = 0; n_pass = 0; n_fail = 0;
        #2;
        do_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_state("post_rst");

        // First transaction, one-cycle latency.
        in_valid = 1'b1; out_ready = 1'b1; mem_addr = 26'h000_0123;
        cycle("first");
        chk("first.addr_const", 32'(addr), 32'h00_0123);
        in_valid = 1'b0;
        cycle("first_drain");

        // Out-of-range entry, then clear colliding with another error.
        in_valid = 1'b1; mem_addr = 26'h100_0005;
        cycle("err1");
        chk("err1.range_err_const", 32'(range_err), 32'd1);
        chk("err1.addr_const", 32'(addr), 32'h00_0005);
        chk("err1.count_const", 32'(err_count), 32'd1);
        mem_addr = 26'h300_0007; clr_count = 1'b1;
        cycle("err_clr");
        chk("err_clr.count_const", 32'(err_count), 32'd0);
        clr_count = 1'b0; in_valid = 1'b0;
        cycle("err_drain");

        // Backpressure: A, B fill both slots, C waits.
        out_ready = 1'b0; in_valid = 1'b1;
        mem_addr = 26'h10; cycle("bp_a");
        mem_addr = 26'h11; cycle("bp_b");
        mem_addr = 26'h12; cycle("bp_c_hold");
        chk("bp.in_ready_low", 32'(in_ready), 32'd0);
        cycle("bp_c_hold2");
        out_ready = 1'b1;
        cycle("bp_rel1");
        chk("bp.second_out", 32'(addr), 32'h11);
        cycle("bp_rel2");
        chk("bp.third_out", 32'(addr), 32'h12);
        in_valid = 1'b0;
        cycle("bp_rel3");
        chk("bp.empty", 32'(out_valid), 32'd0);

        // Sequential run including an error in the middle and a 24-bit wrap.
        seq_addr = '{26'h000_0010, 26'h000_0011, 26'h200_0050, 26'h000_0012, 26'h0FF_FFFF, 26'h000_0000};
`ifdef ADDR_DEC_SEQ_EN
        seq_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        seq_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mem_addr = seq_addr[i];
            cycle("seq_run");
            chk($sformatf("seq_const%0d", i), 32'(seq), 32'(seq_exp[i]));
        end
        in_valid = 1'b0;
        cycle("seq_drain");

        // Saturation of the error counter.
        clr_count = 1'b1; cycle("sat_clr");
        clr_count = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < CNT_TOP + 5; i++) begin
            mem_addr = {2'b01, 24'(i)};
            cycle("sat");
        end
        chk("sat.count_const", 32'(err_count), 32'(CNT_TOP));
        in_valid = 1'b0;
        cycle("sat_drain");

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clr_count = ($urandom_range(0, 15) == 0);
            hi = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            lo = ($urandom_range(0, 1) == 0) ? 24'(pg + 1) : 24'($urandom);
            mem_addr = {hi, lo};
            cycle("rand");
        end
        clr_count = 1'b0;

        // Reset while both slots are full.
        out_ready = 1'b0; in_valid = 1'b1;
        mem_addr = 26'h0AA; cycle("rst_fill_a");
        mem_addr = 26'h0AB; cycle("rst_fill_b");
        mem_addr = 26'h0AC; cycle("rst_fill_c");
        #2;
        do_reset();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        cycle("post_rst2");
        chk("post_rst2.no_stale", 32'(out_valid), 32'd0);
        in_valid = 1'b1; mem_addr = 26'h000_0001;
        cycle("post_rst2_first");
        chk("post_rst2.seq_first", 32'(seq), 32'd0);
        in_valid = 1'b0;
        cycle("post_rst2_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_addr_decoder.md
Name: mem_addr_decoder

Overview:
- Reverse direction of the sample-to-memory address encoder: accepts 26-bit memory-bus addresses and recovers the 24-bit sample address.
- Sits between the external-RAM controller's address/return path and the playback/DSP logic.
- Range-checks the two upper bits (must be 2'b00), counts violations, and optionally flags sequential addresses for burst playback.
- Valid/ready on both sides, 2-entry skid buffer; full throughput under backpressure.

Parameters:
- CNT_W, 16, width of saturating range-error counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  mem_addr valid.
- in_ready  output  1  decoder can accept mem_addr this cycle.
- mem_addr  input  26  memory-bus address.
- out_valid  output  1  decoded entry available.
- out_ready  input  1  consumer accepts entry.
- addr  output  24  decoded sample address, mem_addr[23:0].
- range_err  output  1  entry had mem_addr[25:24] != 2'b00.
- seq  output  1  entry is previous good address + 1 (optional feature).
- clr_count  input  1  synchronous clear of err_count.
- err_count  output  CNT_W  saturating count of accepted out-of-range entries.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, addr=0, range_err=0, seq=0, err_count=0, in_ready=1, skid empty, prev_good invalid.
- Accept on input: in_valid & in_ready. Drain on output: out_valid & out_ready.
- Storage: output register (OR) plus skid register (SK); all fields (addr, range_err, seq) travel together.
- in_ready = !SK_full, registered; depends only on state, never combinationally on out_ready.
- Latency: accept in cycle N -> out_valid=1 in cycle N+1 when OR empty or drained in N.
- Storage transitions:
  - Accept, OR empty or draining -> entry loads OR.
  - Accept, OR full and not draining -> entry loads SK; in_ready=0 next cycle.
  - Drain with SK full -> SK moves to OR; in_ready=1 next cycle.
- Ordering: strict FIFO, no drops, no duplicates.
- Outputs stable while out_valid=1 and out_ready=0.
- Decode: addr = mem_addr[23:0]; range_err = |mem_addr[25:24]. Lower bits are passed through unchanged even on error.
- err_count:
  - Increments on each accepted entry with range_err=1; saturates at all-ones.
  - clr_count has priority: if clear and increment occur in the same cycle, result is 0.
  - Registered; reflects an accept one cycle later.
- prev_good:
  - Updated on accept of a non-error entry only.
  - Error entries do not disturb it.
- Reset mid-operation: all buffered entries are discarded immediately; outputs return to reset values asynchronously.

Optional Feature:
- Macro ADDR_DEC_SEQ_EN.
- Defined:
  - seq = 1 when an accepted entry has range_err=0, prev_good is valid, and addr == prev_good + 1 mod 2^24.
  - Wrap is included: 0xFFFFFF -> 0x000000 gives seq=1.
  - First good entry after reset has seq=0; error entries have seq=0.
- Not defined: seq tied 0, prev_good logic omitted; all other behaviour identical.

Test Plan:
- Reset, then mem_addr=26'h0000123 with in_valid=1 and out_ready=1 -> next cycle out_valid=1, addr=24'h000123, range_err=0, err_count=0.
- Accept 26'h1000005 -> addr=24'h000005, range_err=1; err_count=1 the cycle after the accept. Assert clr_count in the same cycle as another error accept -> err_count=0.
- Hold out_ready=0 and present 3 back-to-back entries A=0x10, B=0x11, C=0x12 -> A and B accepted, in_ready=0 while C held. Release out_ready -> outputs A, B, C in order, one per cycle, no loss.
- With ADDR_DEC_SEQ_EN:
  - Sequence 0x000010, 0x000011, 0x2000050, 0x000012 -> seq = 0, 1, 0, 1; the error entry does not break the run.
  - Sequence 0xFFFFFF, 0x000000 -> second entry seq=1.
- Force err_count to all-ones via 2^CNT_W error accepts (or CNT_W reduced to 4 for the bench) -> err_count holds 0xF on further errors.
- Assert rst_n=0 while both OR and SK are full -> out_valid=0 and in_ready=1 immediately, no stale entries after release.
